score_cmd_parser: RTL

- Consumes bytes from the serial RX FIFO read port; sits directly downstream of the FIFO in the FIFO read-clock domain.
- Pops each byte and assembles 5-byte command frames: SYNC, CMD, D0, D1, CSUM.
- Validates each frame, then updates the scoreboard registers (home score, guest score, period) that drive the display logic.
- Reports checksum, unknown-command and inter-byte timeout errors as single-cycle pulses.

---
 rtl/score_cmd_parser_pkg.sv | 30 +++
 rtl/score_sat_add.sv | 25 ++
 rtl/score_cmd_parser.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/score_cmd_parser_pkg.sv
// ----------------------------------------------------------------------------
// score_cmd_parser_pkg : command codes, sync default and FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package score_cmd_parser_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;

   localparam logic [7:0] CMD_SET_HOME   = 8'h01;
   localparam logic [7:0] CMD_SET_GUEST  = 8'h02;
   localparam logic [7:0] CMD_ADD_HOME   = 8'h03;
   localparam logic [7:0] CMD_ADD_GUEST  = 8'h04;
   localparam logic [7:0] CMD_SET_PERIOD = 8'h05;
   localparam logic [7:0] CMD_CLEAR      = 8'h06;

   localparam logic [2:0] LAST_IDX       = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_POP     = 3'd1,
      ST_WAIT    = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_EXEC    = 3'd4
   } state_e;

endpackage

`default_nettype wire

// File: rtl/score_sat_add.sv
// ----------------------------------------------------------------------------
// score_sat_add : 8-bit + 8-bit unsigned add, clamped to MAX
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module score_sat_add #(
   parameter int MAX = 199
) (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic [7:0] sum_o
);

   localparam logic [8:0] c_MAX9 = 9'(MAX);

   logic [8:0] w_sum;

   // Nine-bit sum keeps the carry so 255+255 still clamps correctly.
   assign w_sum = {1'b0, a_i} + {1'b0, b_i};
   assign sum_o = (w_sum > c_MAX9) ? c_MAX9[7:0] : w_sum[7:0];

endmodule

`default_nettype wire

// File: rtl/score_cmd_parser.sv
// ----------------------------------------------------------------------------
// score_cmd_parser : pops FIFO bytes, assembles 5-byte frames, updates scores
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module score_cmd_parser
   import score_cmd_parser_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int         MAX_SCORE = 199,
   parameter int         TIMEOUT   = 50000,
   parameter int         TO_W      = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       DATA_RDY,
   input  logic [7:0] DATA,
   output logic       RD_EN,
   output logic [7:0] HOME,
   output logic [7:0] GUEST,
   output logic [3:0] PERIOD,
   output logic       UPD,
   output logic       ERR_CSUM,
   output logic       ERR_CMD,
   output logic       ERR_TO
);

   localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0] c_TO_ONE  = TO_W'(1);

   state_e          state_q;
   logic [2:0]      idx_q;
   logic [TO_W-1:0] to_cnt_q;
   logic [7:0]      frame_q [1:4];
   logic            rd_en_q;
   logic [7:0]      home_q;
   logic [7:0]      guest_q;
   logic [3:0]      period_q;
   logic            upd_q;
   logic            err_csum_q;
   logic            err_cmd_q;
   logic            err_to_q;

   logic [7:0]      w_cmd;
   logic [7:0]      w_d0;
   logic            w_csum_ok;
   logic [7:0]      w_home_a;
   logic [7:0]      w_guest_a;
   logic [7:0]      home_d;
   logic [7:0]      guest_d;

   assign w_cmd     = frame_q[1];
   assign w_d0      = frame_q[2];
   assign w_csum_ok = ((frame_q[1] ^ frame_q[2] ^ frame_q[3]) == frame_q[4]);

   // SET commands reuse the saturating adder with a zero base so D0 is clamped too.
   assign w_home_a  = (w_cmd == CMD_ADD_HOME)  ? home_q  : 8'd0;
   assign w_guest_a = (w_cmd == CMD_ADD_GUEST) ? guest_q : 8'd0;

   score_sat_add #(
      .MAX   (MAX_SCORE)
   ) u_home_add (
      .a_i   (w_home_a),
      .b_i   (w_d0),
      .sum_o (home_d)
   );

   score_sat_add #(
      .MAX   (MAX_SCORE)
   ) u_guest_add (
      .a_i   (w_guest_a),
      .b_i   (w_d0),
      .sum_o (guest_d)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         idx_q      <= 3'd0;
         to_cnt_q   <= '0;
         for (int i = 1; i <= 4; i++) begin
            frame_q[i] <= 8'd0;
         end
         rd_en_q    <= 1'b0;
         home_q     <= 8'd0;
         guest_q    <= 8'd0;
         period_q   <= 4'd0;
         upd_q      <= 1'b0;
         err_csum_q <= 1'b0;
         err_cmd_q  <= 1'b0;
         err_to_q   <= 1'b0;
      end else begin
         rd_en_q    <= 1'b0;
         upd_q      <= 1'b0;
         err_csum_q <= 1'b0;
         err_cmd_q  <= 1'b0;
         err_to_q   <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (DATA_RDY) begin
                  state_q <= ST_POP;
                  rd_en_q <= 1'b1;
               end else if (idx_q != 3'd0) begin
                  if (to_cnt_q == c_TO_LAST) begin
                     err_to_q <= 1'b1;
                     idx_q    <= 3'd0;
                     to_cnt_q <= '0;
                  end else begin
                     to_cnt_q <= to_cnt_q + c_TO_ONE;
                  end
               end
            end

            ST_POP:  state_q <= ST_WAIT;

            ST_WAIT: state_q <= ST_CAPTURE;

            ST_CAPTURE: begin
               to_cnt_q <= '0;
               if (idx_q != 3'd0) begin
                  frame_q[idx_q] <= DATA;
               end
               // Only slot 0 is checked against SYNC; later slots carry raw data.
               if ((idx_q == 3'd0) && (DATA != SYNC_BYTE)) begin
                  state_q <= ST_IDLE;
               end else if (idx_q == LAST_IDX) begin
                  state_q <= ST_EXEC;
               end else begin
                  idx_q <= idx_q + 3'd1;
                  if (DATA_RDY) begin
                     state_q <= ST_POP;
                     rd_en_q <= 1'b1;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end

            ST_EXEC: begin
               idx_q   <= 3'd0;
               state_q <= ST_IDLE;
               if (!w_csum_ok) begin
                  err_csum_q <= 1'b1;
               end else begin
                  case (w_cmd)
                     CMD_SET_HOME, CMD_ADD_HOME: begin
                        home_q <= home_d;
                        upd_q  <= 1'b1;
                     end
                     CMD_SET_GUEST, CMD_ADD_GUEST: begin
                        guest_q <= guest_d;
                        upd_q   <= 1'b1;
                     end
                     CMD_SET_PERIOD: begin
                        period_q <= w_d0[3:0];
                        upd_q    <= 1'b1;
                     end
                     CMD_CLEAR: begin
                        home_q   <= 8'd0;
                        guest_q  <= 8'd0;
                        period_q <= 4'd0;
                        upd_q    <= 1'b1;
                     end
                     default: err_cmd_q <= 1'b1;
                  endcase
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign RD_EN    = rd_en_q;
   assign HOME     = home_q;
   assign GUEST    = guest_q;
   assign PERIOD   = period_q;
   assign UPD      = upd_q;
   assign ERR_CSUM = err_csum_q;
   assign ERR_CMD  = err_cmd_q;
   assign ERR_TO   = err_to_q;

endmodule

`default_nettype wire
